// File: rtl/lag_measure.sv
// Multi-channel display-lag measurement core.
// Each sensor channel is optionally inverted, synchronised and debounced; after
// a start pulse the core counts clock cycles until each enabled channel goes
// active, reports per-measurement lags and a running windowed average.
module lag_measure #(
    parameter int                     NUM_SENSORS       = 1,
    parameter int                     COUNTER_WIDTH     = 24,
    parameter int                     DEBOUNCE_CYCLES   = 16,
    parameter int                     TIMEOUT_CYCLES    = 2 ** 23,
    parameter logic [NUM_SENSORS-1:0] SENSOR_ACTIVE_LOW = '0,
    parameter int                     AVG_SHIFT         = 3
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic [NUM_SENSORS-1:0]                 sensor,
    input  logic [NUM_SENSORS-1:0]                 channel_enable,
    output logic                                   busy,
    output logic                                   result_valid,
    output logic [NUM_SENSORS*COUNTER_WIDTH-1:0]   result_lag,
    output logic [NUM_SENSORS-1:0]                 result_timeout,
    output logic                                   avg_valid,
    output logic [NUM_SENSORS*COUNTER_WIDTH-1:0]   avg_lag,
    output logic [NUM_SENSORS-1:0]                 avg_timeout
);

    localparam int              W        = COUNTER_WIDTH;
    localparam int              AW       = W + AVG_SHIFT;
    localparam int              WCW      = (AVG_SHIFT > 0) ? AVG_SHIFT : 1;
    localparam logic [WCW-1:0]  WIN_LAST = WCW'((1 << AVG_SHIFT) - 1);
    localparam logic [W-1:0]    LAG_MAX  = '1;
    localparam logic [W-1:0]    TIMEOUT_VAL = W'(TIMEOUT_CYCLES);
    localparam int              DBW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DBW-1:0]  DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEASURE,
        S_DONE
    } state_t;

    logic [NUM_SENSORS-1:0] deb_level;

    // ------------------------------------------------------------------
    // Per-channel input conditioning: inversion, 2-FF sync, debounce
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_SENSORS; gi++) begin : g_chan
        logic           sync0_reg;
        logic           sync1_reg;
        logic           level_reg;
        logic [DBW-1:0] count_reg;

        // Synchronise the raw level, then flip the debounced level only after
        // DEBOUNCE_CYCLES consecutive disagreeing samples.
        always_ff @(posedge clock) begin
            if (reset) begin
                sync0_reg <= 1'b0;
                sync1_reg <= 1'b0;
                level_reg <= 1'b0;
                count_reg <= '0;
            end else begin
                sync0_reg <= sensor[gi] ^ SENSOR_ACTIVE_LOW[gi];
                sync1_reg <= sync0_reg;
                if (sync1_reg != level_reg) begin
                    if (count_reg == DB_LAST) begin
                        level_reg <= sync1_reg;
                        count_reg <= '0;
                    end else begin
                        count_reg <= count_reg + 1'b1;
                    end
                end else begin
                    count_reg <= '0;
                end
            end
        end

        assign deb_level[gi] = level_reg;
    end

    // ------------------------------------------------------------------
    // Measurement state
    // ------------------------------------------------------------------
    state_t                 state_reg;
    logic [W-1:0]           counter_reg;
    logic [NUM_SENSORS-1:0] en_reg;
    logic [NUM_SENSORS-1:0] hit_reg;
    logic [W-1:0]           lag_reg        [NUM_SENSORS];
    logic [W-1:0]           result_lag_reg [NUM_SENSORS];
    logic [W-1:0]           avg_lag_reg    [NUM_SENSORS];
    logic [AW-1:0]          acc_reg        [NUM_SENSORS];
    logic [NUM_SENSORS-1:0] sticky_reg;
    logic [WCW-1:0]         win_reg;
    logic                   result_valid_reg;
    logic                   avg_valid_reg;
    logic [NUM_SENSORS-1:0] result_timeout_reg;
    logic [NUM_SENSORS-1:0] avg_timeout_reg;

    logic [NUM_SENSORS-1:0] hit_next;
    logic                   all_hit;
    logic [NUM_SENSORS-1:0] sample_to;
    logic [NUM_SENSORS-1:0] sticky_next;
    logic [W-1:0]           sample_lag [NUM_SENSORS];
    logic [AW-1:0]          acc_sum    [NUM_SENSORS];

    // Hit detection and per-sample values used when closing a measurement.
    always_comb begin
        hit_next    = hit_reg | (en_reg & deb_level);
        all_hit     = &(hit_next | ~en_reg);
        sample_to   = en_reg & ~hit_reg;
        sticky_next = sticky_reg | sample_to;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            sample_lag[i] = '0;
            acc_sum[i]    = acc_reg[i];
            if (en_reg[i]) begin
                sample_lag[i] = hit_reg[i] ? lag_reg[i] : LAG_MAX;
            end
            if (en_reg[i] && hit_reg[i]) begin
                acc_sum[i] = acc_reg[i] + AW'(lag_reg[i]);
            end
        end
    end

    // Control FSM with registered result and averaging outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg          <= S_IDLE;
            counter_reg        <= '0;
            en_reg             <= '0;
            hit_reg            <= '0;
            sticky_reg         <= '0;
            win_reg            <= '0;
            result_valid_reg   <= 1'b0;
            avg_valid_reg      <= 1'b0;
            result_timeout_reg <= '0;
            avg_timeout_reg    <= '0;
            for (int i = 0; i < NUM_SENSORS; i++) begin
                lag_reg[i]        <= '0;
                result_lag_reg[i] <= '0;
                avg_lag_reg[i]    <= '0;
                acc_reg[i]        <= '0;
            end
        end else begin
            result_valid_reg <= 1'b0;
            avg_valid_reg    <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        state_reg   <= S_MEASURE;
                        counter_reg <= '0;
                        hit_reg     <= '0;
                        en_reg      <= channel_enable;
                    end
                end
                S_MEASURE: begin
                    for (int i = 0; i < NUM_SENSORS; i++) begin
                        if (en_reg[i] && !hit_reg[i] && deb_level[i]) begin
                            lag_reg[i] <= counter_reg;
                        end
                    end
                    hit_reg <= hit_next;
                    if (all_hit || counter_reg == TIMEOUT_VAL) begin
                        state_reg <= S_DONE;
                    end else begin
                        counter_reg <= counter_reg + 1'b1;
                    end
                end
                S_DONE: begin
                    state_reg          <= S_IDLE;
                    result_valid_reg   <= 1'b1;
                    result_timeout_reg <= sample_to;
                    for (int i = 0; i < NUM_SENSORS; i++) begin
                        result_lag_reg[i] <= sample_lag[i];
                    end
                    if (win_reg == WIN_LAST) begin
                        avg_valid_reg   <= 1'b1;
                        avg_timeout_reg <= sticky_next;
                        sticky_reg      <= '0;
                        win_reg         <= '0;
                        for (int i = 0; i < NUM_SENSORS; i++) begin
                            avg_lag_reg[i] <= sticky_next[i] ? LAG_MAX : W'(acc_sum[i] >> AVG_SHIFT);
                            acc_reg[i]     <= '0;
                        end
                    end else begin
                        sticky_reg <= sticky_next;
                        win_reg    <= win_reg + 1'b1;
                        for (int i = 0; i < NUM_SENSORS; i++) begin
                            acc_reg[i] <= acc_sum[i];
                        end
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign busy           = (state_reg != S_IDLE);
    assign result_valid   = result_valid_reg;
    assign result_timeout = result_timeout_reg;
    assign avg_valid      = avg_valid_reg;
    assign avg_timeout    = avg_timeout_reg;

    for (genvar gi = 0; gi < NUM_SENSORS; gi++) begin : g_pack
        assign result_lag[gi*W +: W] = result_lag_reg[gi];
        assign avg_lag[gi*W +: W]    = avg_lag_reg[gi];
    end

endmodule

// File: tb/tb_lag_measure.sv
// Directed testbench for lag_measure: 2 channels, 16-bit counters,
// debounce 4 (pipeline constant 6), timeout 1000, window of 4.
module tb_lag_measure;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  sensor;
    logic [1:0]  channel_enable;
    logic        busy;
    logic        result_valid;
    logic [31:0] result_lag;
    logic [1:0]  result_timeout;
    logic        avg_valid;
    logic [31:0] avg_lag;
    logic [1:0]  avg_timeout;

    int total = 0;
    int bad   = 0;

    lag_measure #(
        .NUM_SENSORS      (2),
        .COUNTER_WIDTH    (16),
        .DEBOUNCE_CYCLES  (4),
        .TIMEOUT_CYCLES   (1000),
        .SENSOR_ACTIVE_LOW(2'b00),
        .AVG_SHIFT        (2)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .sensor        (sensor),
        .channel_enable(channel_enable),
        .busy          (busy),
        .result_valid  (result_valid),
        .result_lag    (result_lag),
        .result_timeout(result_timeout),
        .avg_valid     (avg_valid),
        .avg_lag       (avg_lag),
        .avg_timeout   (avg_timeout)
    );

    always #5 clock = ~clock;

    // Runs one measurement. Sensor ch0 rises at counter k0, ch1 at k1
    // (negative = never); ch1 glitches high for 3 cycles at g1; start is
    // re-pulsed at s_again. n = edges after the start edge until result_valid
    // is seen (-1 if it never arrives). av/b0 capture avg_valid at the result
    // and busy just after the start edge.
    task automatic run_meas(input int k0, input int k1, input int g1, input int s_again,
                            input logic [1:0] en, output int n, output logic av,
                            output logic b0);
        start = 1'b1;
        channel_enable = en;
        @(posedge clock);
        #1;
        start = 1'b0;
        n = 0;
        b0 = busy;
        if (k0 == 0) sensor[0] = 1'b1;
        if (k1 == 0) sensor[1] = 1'b1;
        while (!result_valid && n < 2000) begin
            @(posedge clock);
            #1;
            n++;
            start = (n == s_again) ? 1'b1 : 1'b0;
            if (n == k0) sensor[0] = 1'b1;
            if (n == k1) sensor[1] = 1'b1;
            if (g1 >= 0 && n == g1) sensor[1] = 1'b1;
            if (g1 >= 0 && n == g1 + 3) sensor[1] = 1'b0;
        end
        start = 1'b0;
        av = avg_valid;
        if (n >= 2000) n = -1;
        $display("meas en=%b n=%0d lag=%h to=%b avg_valid=%b avg=%h avg_to=%b",
                 en, n, result_lag, result_timeout, av, avg_lag, avg_timeout);
    endtask

    task automatic settle();
        sensor = 2'b00;
        repeat (12) @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        sensor = 2'b00;
        channel_enable = 2'b00;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        total += 7;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (result_valid !== 1'b0) begin bad++; $display("FAIL reset_rv got=%b exp=0", result_valid); end
        if (result_lag !== 32'h0) begin bad++; $display("FAIL reset_lag got=%h exp=0", result_lag); end
        if (result_timeout !== 2'b00) begin bad++; $display("FAIL reset_rto got=%b exp=00", result_timeout); end
        if (avg_valid !== 1'b0) begin bad++; $display("FAIL reset_av got=%b exp=0", avg_valid); end
        if (avg_lag !== 32'h0) begin bad++; $display("FAIL reset_avg got=%h exp=0", avg_lag); end
        if (avg_timeout !== 2'b00) begin bad++; $display("FAIL reset_ato got=%b exp=00", avg_timeout); end
    endtask

    task automatic test_two_channels();
        int n; logic av, b0;
        run_meas(100, 250, -1, -1, 2'b11, n, av, b0);
        total += 6;
        if (b0 !== 1'b1) begin bad++; $display("FAIL two_busy_start got=%b exp=1", b0); end
        if (n != 258) begin bad++; $display("FAIL two_latency got=%0d exp=258", n); end
        if (busy !== 1'b0) begin bad++; $display("FAIL two_busy_end got=%b exp=0", busy); end
        if (result_lag !== {16'd256, 16'd106}) begin bad++; $display("FAIL two_lag got=%h exp=%h", result_lag, {16'd256, 16'd106}); end
        if (result_timeout !== 2'b00) begin bad++; $display("FAIL two_to got=%b exp=00", result_timeout); end
        if (av !== 1'b0) begin bad++; $display("FAIL two_av got=%b exp=0", av); end
        settle();
    endtask

    task automatic test_timeout();
        int n; logic av, b0;
        run_meas(20, -1, 50, -1, 2'b11, n, av, b0);
        total += 3;
        if (n != 1002) begin bad++; $display("FAIL to_latency got=%0d exp=1002", n); end
        if (result_lag !== {16'hFFFF, 16'd26}) begin bad++; $display("FAIL to_lag got=%h exp=%h", result_lag, {16'hFFFF, 16'd26}); end
        if (result_timeout !== 2'b10) begin bad++; $display("FAIL to_flag got=%b exp=10", result_timeout); end
        settle();
    endtask

    task automatic test_enable_mask();
        int n; logic av, b0;
        run_meas(30, -1, -1, -1, 2'b01, n, av, b0);
        total += 3;
        if (n != 38) begin bad++; $display("FAIL mask_latency got=%0d exp=38", n); end
        if (result_lag !== {16'd0, 16'd36}) begin bad++; $display("FAIL mask_lag got=%h exp=%h", result_lag, {16'd0, 16'd36}); end
        if (result_timeout !== 2'b00) begin bad++; $display("FAIL mask_to got=%b exp=00", result_timeout); end
        settle();
    endtask

    // Also the 4th measurement since reset: window ch0 = 106,26,36,66 -> 58;
    // ch1 timed out in the window.
    task automatic test_start_ignored();
        int n; logic av, b0;
        run_meas(60, -1, -1, 40, 2'b01, n, av, b0);
        total += 5;
        if (n != 68) begin bad++; $display("FAIL restart_latency got=%0d exp=68", n); end
        if (result_lag[15:0] !== 16'd66) begin bad++; $display("FAIL restart_lag got=%0d exp=66", result_lag[15:0]); end
        if (av !== 1'b1) begin bad++; $display("FAIL win1_av got=%b exp=1", av); end
        if (avg_lag !== {16'hFFFF, 16'd58}) begin bad++; $display("FAIL win1_avg got=%h exp=%h", avg_lag, {16'hFFFF, 16'd58}); end
        if (avg_timeout !== 2'b10) begin bad++; $display("FAIL win1_ato got=%b exp=10", avg_timeout); end
        settle();
    endtask

    task automatic test_average();
        int n; logic av, b0;
        int ks[5] = '{94, 95, 96, 98, 10};
        for (int m = 0; m < 5; m++) begin
            run_meas(ks[m], -1, -1, -1, 2'b01, n, av, b0);
            total += 1;
            if (av !== (m == 3)) begin bad++; $display("FAIL avg_pulse_%0d got=%b exp=%b", m, av, (m == 3)); end
            if (m == 3) begin
                total += 2;
                if (avg_lag !== {16'd0, 16'd101}) begin bad++; $display("FAIL avg_value got=%h exp=%h", avg_lag, {16'd0, 16'd101}); end
                if (avg_timeout !== 2'b00) begin bad++; $display("FAIL avg_to got=%b exp=00", avg_timeout); end
            end
            settle();
        end
    endtask

    task automatic test_reset_mid();
        int n; logic av, b0;
        int ks[4] = '{10, 20, 30, 40};
        start = 1'b1;
        channel_enable = 2'b11;
        @(posedge clock);
        #1;
        start = 1'b0;
        n = 0;
        while (n < 300) begin
            @(posedge clock);
            #1;
            n++;
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        total += 5;
        if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b exp=0", busy); end
        if (result_lag !== 32'h0) begin bad++; $display("FAIL mid_lag got=%h exp=0", result_lag); end
        if (result_timeout !== 2'b00) begin bad++; $display("FAIL mid_rto got=%b exp=00", result_timeout); end
        if (avg_lag !== 32'h0) begin bad++; $display("FAIL mid_avg got=%h exp=0", avg_lag); end
        if (avg_timeout !== 2'b00) begin bad++; $display("FAIL mid_ato got=%b exp=00", avg_timeout); end
        for (int m = 0; m < 4; m++) begin
            run_meas(ks[m], -1, -1, -1, 2'b01, n, av, b0);
            total += 2;
            if (n != ks[m] + 8) begin bad++; $display("FAIL fresh_latency_%0d got=%0d exp=%0d", m, n, ks[m] + 8); end
            if (av !== (m == 3)) begin bad++; $display("FAIL fresh_pulse_%0d got=%b exp=%b", m, av, (m == 3)); end
            settle();
        end
        total += 1;
        if (avg_lag[15:0] !== 16'd31) begin bad++; $display("FAIL fresh_avg got=%0d exp=31", avg_lag[15:0]); end
    endtask

    // Second start lands in the cycle result_valid is visible, with the sensor
    // still held active: it must be accepted and report lag 0.
    task automatic test_back_to_back();
        int n; logic av, b0;
        run_meas(20, -1, -1, -1, 2'b01, n, av, b0);
        total += 1;
        if (result_lag[15:0] !== 16'd26) begin bad++; $display("FAIL b2b_first got=%0d exp=26", result_lag[15:0]); end
        run_meas(0, -1, -1, -1, 2'b01, n, av, b0);
        total += 3;
        if (b0 !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%b exp=1", b0); end
        if (n != 2) begin bad++; $display("FAIL b2b_latency got=%0d exp=2", n); end
        if (result_lag[15:0] !== 16'd0) begin bad++; $display("FAIL b2b_lag got=%0d exp=0", result_lag[15:0]); end
        settle();
    endtask

    initial begin
        test_reset();
        test_two_channels();
        test_timeout();
        test_enable_mask();
        test_start_ignored();
        test_average();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
